lab5_fetch_seq: RTL and testbench

Instruction fetch sequencer: the initiator side of the instruction-memory interface. It owns the byte-addressed program counter, drives the 8-bit instruction-memory address, and captures the returned 16-bit word into an instruction register for the datapath. It resolves branches from datapath comparison flags and stops on HALT. Single-step and free-run modes support board-level debugging.

---
 rtl/lab5_fetch_seq.sv | 117 +++++++++++
 tb/tb_lab5_fetch_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lab5_fetch_seq.sv
// rtl/lab5_fetch_seq.sv - instruction fetch sequencer: PC, IR, branch resolution, halt, single-step
module lab5_fetch_seq #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'h0001
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RUN,
  input  logic        STEP,
  input  logic        RS_EQ_RT,
  input  logic        RS_NEG,
  input  logic [15:0] Q,
  output logic [7:0]  ADDR,
  output logic [15:0] INSTR,
  output logic        INSTR_VALID,
  output logic [7:0]  PC_OUT,
  output logic        HALTED,
  output logic [15:0] ICOUNT
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_PAUSE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] icount_q, icount_d;
  logic        step_prev_q, step_prev_d;

  logic        step_rise;
  logic        taken;
  logic [7:0]  next_pc;
  logic [7:0]  br_offset;
  logic [7:0]  br_target;

  // Word-granular imm6 becomes a signed byte offset: sign-extend then shift left by one.
  assign next_pc   = pc_q + 8'd2;
  assign br_offset = {instr_q[5], instr_q[5:0], 1'b0};
  assign br_target = next_pc + br_offset;
  assign step_rise = STEP & ~step_prev_q;

  always_comb begin
    taken = 1'b0;
    case (instr_q[15:12])
      4'b1000: taken = RS_EQ_RT;
      4'b1001: taken = ~RS_EQ_RT;
      4'b1010: taken = ~RS_NEG;
      4'b1011: taken = RS_NEG;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    icount_d    = icount_q;
    step_prev_d = STEP;
    case (state_q)
      S_FETCH: begin
        instr_d = Q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (icount_q != 16'hFFFF) begin
          icount_d = icount_q + 16'd1;
        end
        if (instr_q == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          pc_d    = (taken ? br_target : next_pc) & 8'hFE;
          state_d = RUN ? S_FETCH : S_PAUSE;
        end
      end
      // A step edge only counts here; edges in other states are dropped, not queued.
      S_PAUSE: begin
        if (RUN || step_rise) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        step_prev_d = step_prev_q;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC & 8'hFE;
      instr_q     <= 16'h0000;
      icount_q    <= 16'h0000;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      icount_q    <= icount_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign ADDR        = pc_q;
  assign PC_OUT      = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = (state_q == S_EXEC);
  assign HALTED      = (state_q == S_HALT);
  assign ICOUNT      = icount_q;

endmodule

// File: tb/tb_lab5_fetch_seq.sv
// tb/tb_lab5_fetch_seq.sv - directed scoreboard bench for lab5_fetch_seq
module tb_lab5_fetch_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RUN;
  logic        STEP;
  logic        RS_EQ_RT;
  logic        RS_NEG;
  logic [15:0] Q;
  logic [7:0]  ADDR;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic [7:0]  PC_OUT;
  logic        HALTED;
  logic [15:0] ICOUNT;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        eq;
    logic        neg;
    logic [7:0]  next;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [0:127];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  lab5_fetch_seq dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
    .RS_EQ_RT(RS_EQ_RT), .RS_NEG(RS_NEG), .Q(Q),
    .ADDR(ADDR), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .PC_OUT(PC_OUT), .HALTED(HALTED), .ICOUNT(ICOUNT)
  );

  always #5 CLK = ~CLK;
  assign Q = mem[ADDR[7:1]];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] pc, input logic [15:0] instr,
                     input logic eq, input logic neg, input logic [7:0] next);
    exp_t e;
    mem[pc[7:1]] = instr;
    e.pc = pc; e.instr = instr; e.eq = eq; e.neg = neg; e.next = next;
    sb.push_back(e);
  endtask

  // Called in FETCH; leaves the bench one cycle after EXEC.
  task automatic fetch_exec(input logic step_in_exec);
    exp_t e;
    n_chk++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected >0");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      RS_EQ_RT = e.eq;
      RS_NEG   = e.neg;
      chk("fetch_addr", {8'h00, ADDR}, {8'h00, e.pc});
      chk("fetch_valid", {15'h0, INSTR_VALID}, 16'h0000);
      tick();
      if (step_in_exec) STEP = 1'b1;
      chk("exec_valid", {15'h0, INSTR_VALID}, 16'h0001);
      chk("exec_instr", INSTR, e.instr);
      chk("exec_pc_out", {8'h00, PC_OUT}, {8'h00, e.pc});
      tick();
      exp_cnt++;
      chk("next_addr", {8'h00, ADDR}, {8'h00, e.next});
      chk("icount", ICOUNT, exp_cnt);
      RS_EQ_RT = $urandom_range(0, 1);
      RS_NEG   = $urandom_range(0, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h7000;
    RESET = 1'b1; RUN = $urandom_range(0, 1); STEP = $urandom_range(0, 1);
    RS_EQ_RT = $urandom_range(0, 1); RS_NEG = $urandom_range(0, 1);

    // Program walk: sequential, taken/not-taken branches of each kind, wrap, halt.
    put(8'h00, 16'h1000, 1'b0, 1'b0, 8'h02);
    put(8'h02, 16'h2000, 1'b0, 1'b0, 8'h04);
    put(8'h04, 16'h3000, 1'b0, 1'b0, 8'h06);
    put(8'h06, 16'h4000, 1'b0, 1'b0, 8'h08);
    put(8'h08, 16'h820F, 1'b1, 1'b0, 8'h28);
    put(8'h28, 16'hB00A, 1'b1, 1'b0, 8'h2A);
    put(8'h2A, 16'hA03D, 1'b0, 1'b0, 8'h26);
    put(8'h26, 16'h9E34, 1'b0, 1'b1, 8'h10);
    put(8'h10, 16'h820F, 1'b0, 1'b1, 8'h12);
    put(8'h12, 16'hB035, 1'b0, 1'b1, 8'hFE);
    put(8'hFE, 16'h5000, 1'b1, 1'b1, 8'h00);
    put(8'h00, 16'h1000, 1'b0, 1'b0, 8'h02);
    put(8'h02, 16'h2000, 1'b0, 1'b0, 8'h04);
    put(8'h04, 16'h3000, 1'b0, 1'b0, 8'h06);
    put(8'h06, 16'h4000, 1'b0, 1'b0, 8'h08);
    put(8'h08, 16'h820F, 1'b0, 1'b0, 8'h0A);
    put(8'h0A, 16'h8017, 1'b1, 1'b0, 8'h3A);
    mem[8'h3A >> 1] = 16'h0001;

    tick(); tick();
    chk("rst_addr", {8'h00, ADDR}, 16'h0000);
    chk("rst_instr", INSTR, 16'h0000);
    chk("rst_halted", {15'h0, HALTED}, 16'h0000);
    chk("rst_icount", ICOUNT, 16'h0000);
    chk("rst_valid", {15'h0, INSTR_VALID}, 16'h0000);

    RESET = 1'b0; RUN = 1'b1; STEP = 1'b0;
    while (sb.size() > 0) fetch_exec(1'b0);

    // HALT word at 0x3A.
    chk("halt_fetch_addr", {8'h00, ADDR}, 16'h003A);
    tick();
    chk("halt_exec_valid", {15'h0, INSTR_VALID}, 16'h0001);
    chk("halt_exec_instr", INSTR, 16'h0001);
    tick();
    chk("halted", {15'h0, HALTED}, 16'h0001);
    chk("halt_icount", ICOUNT, 16'd18);
    for (int i = 0; i < 20; i++) begin
      STEP = ~STEP;
      chk("halt_hold_addr", {8'h00, ADDR}, 16'h003A);
      chk("halt_hold_valid", {15'h0, INSTR_VALID}, 16'h0000);
      tick();
    end
    chk("halt_sticky", {15'h0, HALTED}, 16'h0001);

    RESET = 1'b1;
    tick();
    chk("rst2_addr", {8'h00, ADDR}, 16'h0000);
    chk("rst2_halted", {15'h0, HALTED}, 16'h0000);
    chk("rst2_icount", ICOUNT, 16'h0000);
    chk("rst2_instr", INSTR, 16'h0000);

    // Single-step: STEP edge during EXEC is dropped, held-high STEP gives one step.
    RESET = 1'b0; RUN = 1'b0; STEP = 1'b0; exp_cnt = 16'd0;
    put(8'h00, 16'h1000, 1'b0, 1'b0, 8'h02);
    put(8'h02, 16'h2000, 1'b0, 1'b0, 8'h04);
    put(8'h04, 16'h3000, 1'b0, 1'b0, 8'h06);
    fetch_exec(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("pause_addr", {8'h00, ADDR}, 16'h0002);
      chk("pause_valid", {15'h0, INSTR_VALID}, 16'h0000);
      tick();
    end
    chk("pause_icount", ICOUNT, 16'd1);
    STEP = 1'b0;
    tick();
    STEP = 1'b1;
    tick();
    fetch_exec(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("pause2_addr", {8'h00, ADDR}, 16'h0004);
      chk("pause2_valid", {15'h0, INSTR_VALID}, 16'h0000);
      tick();
    end
    RUN = 1'b1;
    tick();
    fetch_exec(1'b0);
    chk("resume_free_run", {15'h0, INSTR_VALID}, 16'h0000);
    tick();
    chk("resume_exec", {15'h0, INSTR_VALID}, 16'h0001);
    chk("resume_instr", INSTR, 16'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
